// File: rtl/iomem_timer.sv
// Memory-mapped down-counting timer with prescaler and interrupt flag.
// Single-cycle acknowledged bus slave selected by the top address byte.
module iomem_timer #(
  parameter logic [7:0] BASE_HI = 8'h04
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [31:0] iomem_addr,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq
);

  logic        r_en;
  logic        r_auto;
  logic        r_irqen;
  logic [15:0] r_presc;
  logic [31:0] r_count;
  logic [31:0] r_reload;
  logic        r_flag;
  logic [15:0] r_psc;
  logic        r_ready;
  logic [31:0] r_rdata;

  logic        w_sel;
  logic        w_wr;
  logic [1:0]  w_off;
  logic        w_wr_ctrl;
  logic        w_wr_count;
  logic        w_wr_reload;
  logic        w_clr;
  logic        w_tick;
  logic        w_expire;
  logic [31:0] w_mask;
  logic [31:0] w_ctrl;
  logic [31:0] w_rd;
  logic        w_unused;

  assign w_sel = iomem_valid && !r_ready &&
                 (iomem_addr[31:24] == BASE_HI);
  assign w_wr = w_sel && (iomem_wstrb != 4'b0000);
  assign w_off = iomem_addr[3:2];
  assign w_wr_ctrl = w_wr && (w_off == 2'd0);
  assign w_wr_count = w_wr && (w_off == 2'd1);
  assign w_wr_reload = w_wr && (w_off == 2'd2);
  assign w_clr = w_wr && (w_off == 2'd3) &&
                 iomem_wstrb[0] && iomem_wdata[0];

  assign w_mask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                   {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};

  assign w_tick = r_en && (r_psc == r_presc);
  // A bus write to COUNT consumes the tick, including any expiry.
  assign w_expire = w_tick && (r_count == 32'd1) && !w_wr_count;

  assign w_ctrl = {r_presc, 13'd0, r_irqen, r_auto, r_en};
  assign w_unused = ^{iomem_addr[23:4], iomem_addr[1:0]};

  // Register read mux, sampled as the pre-write value.
  always_comb begin
    w_rd = 32'd0;
    unique case (w_off)
      2'd0: w_rd = w_ctrl;
      2'd1: w_rd = r_count;
      2'd2: w_rd = r_reload;
      2'd3: w_rd = {31'd0, r_flag};
    endcase
  end

  // Bus acknowledge and read data, one cycle per request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_ready <= w_sel;
      r_rdata <= w_sel ? w_rd : 32'd0;
    end
  end

  // CTRL fields with byte-lane strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_en    <= 1'b0;
      r_auto  <= 1'b0;
      r_irqen <= 1'b0;
      r_presc <= 16'd0;
    end else if (w_wr_ctrl) begin
      if (iomem_wstrb[0]) begin
        r_en    <= iomem_wdata[0];
        r_auto  <= iomem_wdata[1];
        r_irqen <= iomem_wdata[2];
      end
      if (iomem_wstrb[2]) r_presc[7:0] <= iomem_wdata[23:16];
      if (iomem_wstrb[3]) r_presc[15:8] <= iomem_wdata[31:24];
    end
  end

  // Prescaler: restarts on disable or any CTRL write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_psc <= 16'd0;
    end else if (!r_en || w_wr_ctrl || w_tick) begin
      r_psc <= 16'd0;
    end else begin
      r_psc <= r_psc + 16'd1;
    end
  end

  // COUNT: bus write wins over the tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 32'd0;
    end else if (w_wr_count) begin
      r_count <= (r_count & ~w_mask) | (iomem_wdata & w_mask);
    end else if (w_tick) begin
      if (r_count > 32'd1) begin
        r_count <= r_count - 32'd1;
      end else if (r_count == 32'd1) begin
        r_count <= r_auto ? r_reload : 32'd0;
      end
    end
  end

  // RELOAD: plain byte-strobed register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_reload <= 32'd0;
    end else if (w_wr_reload) begin
      r_reload <= (r_reload & ~w_mask) | (iomem_wdata & w_mask);
    end
  end

  // FLAG: hardware set beats write-1-to-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flag <= 1'b0;
    end else if (w_expire) begin
      r_flag <= 1'b1;
    end else if (w_clr) begin
      r_flag <= 1'b0;
    end
  end

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign irq = r_flag && r_irqen;

endmodule

// File: tb/tb_iomem_timer.sv
// Directed bench for iomem_timer with a cycle model and
// hand-computed expectations for the main scenarios.
module tb_iomem_timer;

  localparam logic [31:0] A_CTRL = 32'h0400_0000;
  localparam logic [31:0] A_CNT  = 32'h0400_0004;
  localparam logic [31:0] A_REL  = 32'h0400_0008;
  localparam logic [31:0] A_STAT = 32'h0400_000C;

  logic        clk;
  logic        reset;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [31:0] iomem_addr;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  iomem_timer #(.BASE_HI(8'h04)) dut (
    .clk(clk),
    .reset(reset),
    .iomem_valid(iomem_valid),
    .iomem_ready(iomem_ready),
    .iomem_addr(iomem_addr),
    .iomem_wstrb(iomem_wstrb),
    .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata),
    .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // Model: regs[0]=CTRL, [1]=COUNT, [2]=RELOAD, [3]=STATUS.
  logic [31:0] m_regs [4];
  int          m_phase;
  bit          m_ready;
  logic [31:0] m_rdata;
  bit          m_live = 0;

  always @(posedge clk) begin : model
    logic [31:0] old [4];
    bit sel, wr, tick, set, clr;
    int off, period;
    if (reset) begin
      for (int k = 0; k < 4; k++) m_regs[k] = 32'd0;
      m_phase = 0;
      m_ready = 0;
      m_rdata = 32'd0;
      m_live = 1;
    end else if (m_live) begin
      old = m_regs;
      sel = iomem_valid && !m_ready && (iomem_addr[31:24] == 8'h04);
      off = int'(iomem_addr[3:2]);
      wr = sel && (iomem_wstrb != 4'd0);
      period = int'(old[0][31:16]) + 1;
      tick = old[0][0] && (((m_phase + 1) % period) == 0);
      set = 0;
      m_ready = sel;
      m_rdata = sel ? old[off] : 32'd0;
      if (wr && off == 1) begin
        m_regs[1] = merge(old[1], iomem_wdata, iomem_wstrb);
      end else if (tick) begin
        if (old[1] > 1) begin
          m_regs[1] = old[1] - 1;
        end else if (old[1] == 1) begin
          m_regs[1] = old[0][1] ? old[2] : 32'd0;
          set = 1;
        end
      end
      if (wr && off == 0)
        m_regs[0] = merge(old[0], iomem_wdata, iomem_wstrb) & 32'hFFFF_0007;
      if (wr && off == 2)
        m_regs[2] = merge(old[2], iomem_wdata, iomem_wstrb);
      clr = wr && off == 3 && iomem_wstrb[0] && iomem_wdata[0];
      if (set) m_regs[3] = 32'd1;
      else if (clr) m_regs[3] = 32'd0;
      if (!old[0][0] || (wr && off == 0)) m_phase = 0;
      else m_phase++;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_live) begin
      chk("m_ready", {31'd0, iomem_ready}, {31'd0, m_ready});
      chk("m_irq", {31'd0, irq},
          {31'd0, m_regs[3][0] & m_regs[0][2]});
      if (m_ready) chk("m_rdata", iomem_rdata, m_rdata);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, output logic [31:0] q);
    int n;
    n = 0;
    iomem_valid = 1'b1;
    iomem_addr = a;
    iomem_wstrb = s;
    iomem_wdata = d;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!iomem_ready && n < 8);
    q = iomem_rdata;
    chk("bus_ack", {31'd0, iomem_ready}, 32'd1);
    iomem_valid = 1'b0;
    iomem_wstrb = 4'd0;
  endtask

  logic [31:0] q;

  initial begin
    reset = 1'b1;
    iomem_valid = 1'b0;
    iomem_addr = 32'd0;
    iomem_wstrb = 4'd0;
    iomem_wdata = 32'd0;
    cyc(2);
    chk("rst_ready", {31'd0, iomem_ready}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_rdata", iomem_rdata, 32'd0);
    reset = 1'b0;
    cyc(1);

    // Auto-reload, PRESC=0, period 3
    bus(A_REL, 4'hF, 32'd3, q);
    bus(A_CNT, 4'hF, 32'd3, q);
    bus(A_CTRL, 4'hF, 32'h0000_0007, q);
    cyc(2);
    chk("r29_irq_pre", {31'd0, irq}, 32'd0);
    cyc(1);
    chk("r29_irq_set", {31'd0, irq}, 32'd1);
    bus(32'h04AB_CDE7, 4'h0, 32'd0, q);
    chk("r29_count_reload", q, 32'd3);
    bus(A_CTRL, 4'hF, 32'd0, q);
    bus(A_STAT, 4'h1, 32'd1, q);
    chk("r29_irq_clr", {31'd0, irq}, 32'd0);

    // Clear racing with a fresh expiry
    bus(A_CNT, 4'hF, 32'd2, q);
    bus(A_CTRL, 4'hF, 32'h0000_0007, q);
    cyc(4);
    bus(A_STAT, 4'h1, 32'd1, q);
    chk("r32_flag_kept", {31'd0, irq}, 32'd1);
    bus(A_STAT, 4'h1, 32'd1, q);
    chk("r32_flag_clr", {31'd0, irq}, 32'd0);
    bus(A_CTRL, 4'hF, 32'd0, q);
    bus(A_STAT, 4'h1, 32'd1, q);

    // PRESC=2, one-shot, IRQEN=0
    bus(A_CNT, 4'hF, 32'd2, q);
    bus(A_CTRL, 4'hF, 32'h0002_0001, q);
    cyc(1);
    bus(A_CNT, 4'h0, 32'd0, q);
    chk("r30_cnt2", q, 32'd2);
    cyc(1);
    bus(A_CNT, 4'h0, 32'd0, q);
    chk("r30_cnt1", q, 32'd1);
    cyc(1);
    bus(A_STAT, 4'h0, 32'd0, q);
    chk("r30_flag0", q, 32'd0);
    bus(A_STAT, 4'h0, 32'd0, q);
    chk("r30_flag1", q, 32'd1);
    bus(A_CNT, 4'h0, 32'd0, q);
    chk("r30_cnt0", q, 32'd0);
    chk("r30_irq", {31'd0, irq}, 32'd0);
    bus(A_CTRL, 4'hF, 32'd0, q);
    bus(A_STAT, 4'h1, 32'd1, q);

    // Held-valid reads pulse every other cycle
    bus(A_CNT, 4'hF, 32'd10, q);
    bus(A_CTRL, 4'hF, 32'h0000_0001, q);
    cyc(1);
    iomem_valid = 1'b1;
    iomem_addr = A_CNT;
    iomem_wstrb = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk("r31_ready", {31'd0, iomem_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0)
        chk("r31_rdata", iomem_rdata, 32'(9 - i));
    end
    iomem_valid = 1'b0;
    bus(A_CTRL, 4'hF, 32'd0, q);

    // Partial write suppresses decrement; foreign address ignored
    bus(A_CNT, 4'hF, 32'h50, q);
    bus(A_CTRL, 4'hF, 32'h0000_0001, q);
    cyc(2);
    bus(A_CNT, 4'b0010, 32'h0000_0100, q);
    bus(A_CNT, 4'h0, 32'd0, q);
    chk("r33_bytewr", q, 32'h0000_014D);
    cyc(1);
    iomem_valid = 1'b1;
    iomem_addr = 32'h0300_0000;
    iomem_wstrb = 4'hF;
    iomem_wdata = 32'd0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("r33_noready", {31'd0, iomem_ready}, 32'd0);
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'd0;
    bus(A_CTRL, 4'h0, 32'd0, q);
    chk("r33_ctrl_kept", q, 32'd1);
    bus(A_CTRL, 4'hF, 32'd0, q);

    // Reset mid-count with FLAG set and a pending request
    bus(A_CNT, 4'hF, 32'd1, q);
    bus(A_CTRL, 4'hF, 32'h0000_0007, q);
    cyc(2);
    chk("r34_irq_pre", {31'd0, irq}, 32'd1);
    iomem_valid = 1'b1;
    iomem_addr = A_CNT;
    iomem_wstrb = 4'd0;
    reset = 1'b1;
    cyc(1);
    chk("r34_rst_ready", {31'd0, iomem_ready}, 32'd0);
    chk("r34_rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    cyc(1);
    chk("r34_new_ready", {31'd0, iomem_ready}, 32'd1);
    chk("r34_new_rdata", iomem_rdata, 32'd0);
    iomem_valid = 1'b0;
    bus(A_CTRL, 4'h0, 32'd0, q);
    chk("r34_ctrl0", q, 32'd0);
    bus(A_CNT, 4'h0, 32'd0, q);
    chk("r34_cnt0", q, 32'd0);
    bus(A_REL, 4'h0, 32'd0, q);
    chk("r34_rel0", q, 32'd0);
    bus(A_STAT, 4'h0, 32'd0, q);
    chk("r34_stat0", q, 32'd0);
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iomem_timer.md
IOMEM_TIMER -- requirements
Module: iomem_timer

Interface
REQ-001 The block SHALL have parameter BASE_HI, default 8'h04, meaning the address byte iomem_addr[31:24] that selects this block.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port iomem_valid, input, 1 bit: bus request valid.
REQ-005 The block SHALL have port iomem_ready, output, 1 bit: one-cycle transfer acknowledge.
REQ-006 The block SHALL have port iomem_addr, input, 32 bits: byte address.
REQ-007 The block SHALL have port iomem_wstrb, input, 4 bits: byte write strobes; 0 means read.
REQ-008 The block SHALL have port iomem_wdata, input, 32 bits: write data.
REQ-009 The block SHALL have port iomem_rdata, output, 32 bits: read data, valid while iomem_ready=1.
REQ-010 The block SHALL have port irq, output, 1 bit: level interrupt.

Function
REQ-011 The block SHALL be selected only when iomem_valid=1 and iomem_addr[31:24]=BASE_HI; offset = iomem_addr[3:2], and iomem_addr[23:4] and [1:0] are ignored.
REQ-012 Handshake: a selected request with iomem_ready=0 SHALL produce iomem_ready=1 on the next cycle for exactly one cycle; ready SHALL never be asserted two cycles in a row and SHALL never be asserted for unselected requests.
REQ-013 Reads and writes SHALL take effect in the same edge that raises iomem_ready; iomem_rdata SHALL be the register value before that edge's write.
REQ-014 Register map: offset 0 CTRL, offset 1 COUNT, offset 2 RELOAD, offset 3 STATUS.
REQ-015 CTRL layout: bit0 EN, bit1 AUTO (auto-reload), bit2 IRQEN, bits[15:3] read 0, bits[31:16] PRESC; writes honour byte strobes.
REQ-016 COUNT and RELOAD SHALL be 32-bit read/write registers with per-byte strobes.
REQ-017 STATUS bit0 SHALL be FLAG; writing 1 to wdata[0] with wstrb[0]=1 SHALL clear FLAG; other bits read 0.
REQ-018 Prescaler: a 16-bit prescale counter SHALL run while EN=1, producing one tick every PRESC+1 cycles; PRESC=0 SHALL give a tick every cycle.
REQ-019 The prescale counter SHALL be cleared whenever EN=0 or CTRL is written.
REQ-020 On a tick with COUNT>1, COUNT SHALL decrement by 1.
REQ-021 On a tick with COUNT=1, FLAG SHALL be set, and COUNT SHALL load RELOAD if AUTO=1, else 0.
REQ-022 On a tick with COUNT=0, COUNT SHALL remain 0 and FLAG SHALL be unchanged.
REQ-023 A bus write to COUNT SHALL take priority over a same-cycle tick; the written value is used and no decrement occurs that cycle.
REQ-024 A hardware FLAG set SHALL take priority over a same-cycle write-1-to-clear.
REQ-025 irq SHALL equal FLAG AND IRQEN, combinationally from registered state.
REQ-026 A write to RELOAD SHALL not affect COUNT until the next expiry.

Reset
REQ-027 While reset=1 at a clock edge, CTRL, COUNT, RELOAD, FLAG, the prescale counter, iomem_ready and iomem_rdata SHALL all become 0; irq is therefore 0.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer: no ready, no register update. After reset deasserts, a still-valid request SHALL be served as new.

Verification
REQ-029 Write RELOAD=3 and COUNT=3, then CTRL=0x0007 -> FLAG set and irq=1 exactly 3 cycles after the CTRL write; COUNT then reads 3 and the sequence repeats every 3 cycles.
REQ-030 CTRL=0x0002_0001 with COUNT=2 and AUTO=0 -> COUNT decrements every 3 cycles, FLAG sets after 6 cycles, COUNT holds 0, and irq stays 0 (IRQEN=0).
REQ-031 Back-to-back read of COUNT with valid held high -> ready pulses every other cycle; rdata shows the pre-tick value at each pulse.
REQ-032 FLAG=1, then write STATUS=1 in the same cycle as a new expiry -> FLAG remains 1; a subsequent STATUS=1 write clears it and irq drops the next cycle.
REQ-033 Write COUNT=0x100 with wstrb=0010 while the timer runs -> only byte1 is updated and the decrement is suppressed that cycle; an access at iomem_addr 0x0300_0000 -> no ready.
REQ-034 Assert reset during an active count with FLAG=1 -> all registers read 0, irq=0, and no ready occurs in the reset cycle.
